avm_rs232_frame_bridge: RTL and testbench



---
 rtl/avm_rs232_frame_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_avm_rs232_frame_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_rs232_frame_bridge.sv
// Avalon-MM master bridging the RS232 core and a compute core. It polls RX status,
// packs IN_BYTES bytes into one word, hands it to the core, then writes the result out byte-wise.
module avm_rs232_frame_bridge #(
  parameter int unsigned IN_BYTES    = 4,
  parameter int unsigned OUT_BYTES   = 2,
  parameter int unsigned RX_ADDR     = 0,
  parameter int unsigned TX_ADDR     = 4,
  parameter int unsigned STATUS_ADDR = 8,
  parameter int unsigned RRDY_BIT    = 7,
  parameter int unsigned TRDY_BIT    = 6,
  parameter int unsigned BIG_ENDIAN  = 1
) (
  input  logic                   avm_clk,
  input  logic                   avm_rst,
  output logic [4:0]             avm_address,
  output logic                   avm_read,
  input  logic [31:0]            avm_readdata,
  output logic                   avm_write,
  output logic [31:0]            avm_writedata,
  input  logic                   avm_waitrequest,
  output logic                   core_in_valid,
  input  logic                   core_in_ready,
  output logic [8*IN_BYTES-1:0]  core_in_data,
  input  logic                   core_out_valid,
  output logic                   core_out_ready,
  input  logic [8*OUT_BYTES-1:0] core_out_data,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  localparam int unsigned IW  = 8 * IN_BYTES;
  localparam int unsigned OW  = 8 * OUT_BYTES;
  localparam int unsigned RCW = $clog2(IN_BYTES + 1);
  localparam int unsigned TCW = $clog2(OUT_BYTES + 1);
  localparam logic [4:0] A_RX     = 5'(RX_ADDR);
  localparam logic [4:0] A_TX     = 5'(TX_ADDR);
  localparam logic [4:0] A_STATUS = 5'(STATUS_ADDR);

  typedef enum logic [2:0] {
    RX_POLL,
    RX_READ,
    CORE_SEND,
    CORE_WAIT,
    TX_POLL,
    TX_WRITE
  } state_t;

  state_t         state_q, state_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]  in_data_q, in_data_d;
  logic [OW-1:0]  out_data_q, out_data_d;
  logic [4:0]     addr_q, addr_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [7:0]     wbyte_q, wbyte_d;
  logic           in_valid_q, in_valid_d;
  logic           out_ready_q, out_ready_d;
  logic           busy_q, busy_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           xfer_done;
  int unsigned    rx_lane;
  int unsigned    tx_lane;
  logic           unused_rdata;

  assign xfer_done    = (rd_q | wr_q) & ~avm_waitrequest;
  assign unused_rdata = ^avm_readdata;

  // A command is raised only when the command register is low; since completion clears it,
  // every transfer is followed by exactly one idle cycle before the next one.
  always_comb begin
    state_d     = state_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    in_data_d   = in_data_q;
    out_data_d  = out_data_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    wbyte_d     = wbyte_q;
    in_valid_d  = in_valid_q;
    out_ready_d = out_ready_q;
    frame_cnt_d = frame_cnt_q;
    rx_lane     = (BIG_ENDIAN != 0) ? (IN_BYTES - 1 - 32'(rx_cnt_q)) : 32'(rx_cnt_q);
    tx_lane     = (BIG_ENDIAN != 0) ? (OUT_BYTES - 1 - 32'(tx_cnt_q)) : 32'(tx_cnt_q);

    case (state_q)
      RX_POLL: begin
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = A_STATUS;
        end else if (xfer_done) begin
          rd_d = 1'b0;
          if (avm_readdata[RRDY_BIT]) state_d = RX_READ;
        end
      end
      RX_READ: begin
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = A_RX;
        end else if (xfer_done) begin
          rd_d                     = 1'b0;
          in_data_d[8*rx_lane +: 8] = avm_readdata[7:0];
          rx_cnt_d                 = rx_cnt_q + 1'b1;
          state_d = (rx_cnt_q == RCW'(IN_BYTES - 1)) ? CORE_SEND : RX_POLL;
        end
      end
      CORE_SEND: begin
        if (!in_valid_q) begin
          in_valid_d = 1'b1;
        end else if (core_in_ready) begin
          in_valid_d = 1'b0;
          state_d    = CORE_WAIT;
        end
      end
      CORE_WAIT: begin
        if (!out_ready_q) begin
          out_ready_d = 1'b1;
        end else if (core_out_valid) begin
          out_ready_d = 1'b0;
          out_data_d  = core_out_data;
          tx_cnt_d    = '0;
          state_d     = TX_POLL;
        end
      end
      TX_POLL: begin
        if (!rd_q) begin
          rd_d   = 1'b1;
          addr_d = A_STATUS;
        end else if (xfer_done) begin
          rd_d = 1'b0;
          if (avm_readdata[TRDY_BIT]) state_d = TX_WRITE;
        end
      end
      TX_WRITE: begin
        if (!wr_q) begin
          wr_d    = 1'b1;
          addr_d  = A_TX;
          wbyte_d = out_data_q[8*tx_lane +: 8];
        end else if (xfer_done) begin
          wr_d     = 1'b0;
          tx_cnt_d = tx_cnt_q + 1'b1;
          if (tx_cnt_q == TCW'(OUT_BYTES - 1)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            rx_cnt_d    = '0;
            state_d     = RX_POLL;
          end else begin
            state_d = TX_POLL;
          end
        end
      end
      default: state_d = RX_POLL;
    endcase

    busy_d = !((state_d == RX_POLL) && (rx_cnt_d == '0));
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q     <= RX_POLL;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      in_data_q   <= '0;
      out_data_q  <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wbyte_q     <= '0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      in_data_q   <= in_data_d;
      out_data_q  <= out_data_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      wbyte_q     <= wbyte_d;
      in_valid_q  <= in_valid_d;
      out_ready_q <= out_ready_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = {24'b0, wbyte_q};
  assign core_in_valid  = in_valid_q;
  assign core_in_data   = in_data_q;
  assign core_out_ready = out_ready_q;
  assign busy           = busy_q;
  assign frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_avm_rs232_frame_bridge.sv
// Directed bench for avm_rs232_frame_bridge: one big-endian and one little-endian instance
// share a behavioural RS232 slave and core model selected by sel.
module tb_avm_rs232_frame_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic [31:0] rdata = '0;
  logic        wreq = 1'b0;
  logic        cin_ready, cout_valid;
  logic [15:0] cout_data;

  logic [4:0]  addr_a, addr_b;
  logic        rd_a, rd_b, wr_a, wr_b, civ_a, civ_b, cor_a, cor_b, busy_a, busy_b;
  logic [31:0] wd_a, wd_b, cid_a, cid_b;
  logic [15:0] fc_a, fc_b;

  avm_rs232_frame_bridge #(.BIG_ENDIAN(1)) dut_a (
    .avm_clk(clk), .avm_rst(rst_a), .avm_address(addr_a), .avm_read(rd_a),
    .avm_readdata(rdata), .avm_write(wr_a), .avm_writedata(wd_a),
    .avm_waitrequest(sel ? 1'b1 : wreq), .core_in_valid(civ_a),
    .core_in_ready(sel ? 1'b0 : cin_ready), .core_in_data(cid_a),
    .core_out_valid(sel ? 1'b0 : cout_valid), .core_out_ready(cor_a),
    .core_out_data(cout_data), .busy(busy_a), .frame_count(fc_a)
  );

  avm_rs232_frame_bridge #(.BIG_ENDIAN(0)) dut_b (
    .avm_clk(clk), .avm_rst(rst_b), .avm_address(addr_b), .avm_read(rd_b),
    .avm_readdata(rdata), .avm_write(wr_b), .avm_writedata(wd_b),
    .avm_waitrequest(sel ? wreq : 1'b1), .core_in_valid(civ_b),
    .core_in_ready(sel ? cin_ready : 1'b0), .core_in_data(cid_b),
    .core_out_valid(sel ? cout_valid : 1'b0), .core_out_ready(cor_b),
    .core_out_data(cout_data), .busy(busy_b), .frame_count(fc_b)
  );

  logic        m_rst, m_rd, m_wr, m_civ, m_cor, m_busy;
  logic [4:0]  m_addr;
  logic [31:0] m_wd, m_cid;
  logic [15:0] m_fc;
  assign m_rst  = sel ? rst_b  : rst_a;
  assign m_addr = sel ? addr_b : addr_a;
  assign m_rd   = sel ? rd_b   : rd_a;
  assign m_wr   = sel ? wr_b   : wr_a;
  assign m_wd   = sel ? wd_b   : wd_a;
  assign m_civ  = sel ? civ_b  : civ_a;
  assign m_cid  = sel ? cid_b  : cid_a;
  assign m_cor  = sel ? cor_b  : cor_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_fc   = sel ? fc_b   : fc_a;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural RS232 slave, evaluated on the falling edge.
  byte unsigned rx_q[$];
  byte unsigned tx_log[$];
  logic [3:0]   ops[$];
  bit           wait_mode = 0, hold_en = 0, inprog = 0, gap_pending = 0, expect_cmd = 0;
  bit           last_status = 0, last_rrdy = 0;
  int unsigned  wl = 0, rrdy_block = 0, rx_served = 0;
  logic [38:0]  snap;

  always @(negedge clk) begin
    if (m_rst) begin
      inprog = 0; wreq = 1'b0; gap_pending = 0; expect_cmd = 0; last_status = 0;
    end else begin
      if (gap_pending) begin
        check_val("idle_gap", m_rd | m_wr, 1'b0);
        gap_pending = 0;
      end else if (expect_cmd) begin
        check_val("cmd_after_gap", m_rd | m_wr, 1'b1);
        expect_cmd = 0;
      end
      if (m_rd | m_wr) begin
        check_val("rd_wr_excl", m_rd & m_wr, 1'b0);
        if (!inprog) begin
          inprog = 1;
          snap   = {m_addr, m_rd, m_wr, m_wd};
          wl     = wait_mode ? $urandom_range(4, 1) : 0;
        end else begin
          check_val("cmd_stable", {m_addr, m_rd, m_wr, m_wd}, snap);
        end
        if ((hold_en && rx_served >= 2) || wl > 0) begin
          wreq = 1'b1;
          if (wl > 0) wl--;
        end else begin
          wreq = 1'b0; inprog = 0; gap_pending = 1;
          if (m_rd && m_addr == 5'd8) begin
            rdata      = 32'h0000_0015;
            rdata[7]   = (rx_q.size() > 0) && (rrdy_block == 0);
            rdata[6]   = 1'b1;
            if (rrdy_block > 0) rrdy_block--;
            last_rrdy  = rdata[7];
            last_status = 1; expect_cmd = 1;
            ops.push_back(4'd1);
          end else if (m_rd && m_addr == 5'd0) begin
            check_val("rx_after_rrdy", {last_status, last_rrdy}, 2'b11);
            rdata = {24'hA5A5A5, (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00};
            rx_served++; last_status = 0;
            ops.push_back(4'd2);
          end else if (m_wr && m_addr == 5'd4) begin
            check_val("tx_after_trdy", last_status, 1'b1);
            check_val("wdata_upper", m_wd[31:8], 24'h0);
            tx_log.push_back(m_wd[7:0]);
            last_status = 0;
            ops.push_back(4'd3);
          end else begin
            check_val("bad_access", {m_rd, m_wr, m_addr}, {1'b1, 1'b0, 5'd8});
          end
        end
      end else begin
        wreq = 1'b0;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic load4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) rx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic check_outs_zero(input string tag);
    check_val({tag, "_avm"}, {m_addr, m_rd, m_wr, m_wd}, '0);
    check_val({tag, "_core"}, {m_civ, m_cid, m_cor, m_busy, m_fc}, '0);
  endtask

  task automatic run_frame(input logic [31:0] exp_in, input logic [15:0] res,
                           input int unsigned in_hold, input bit early,
                           input logic [7:0] t0, input logic [7:0] t1, input logic [15:0] exp_fc);
    int unsigned n;
    bit seen_ready;
    tx_log.delete();
    seen_ready = 0;
    if (early) begin cout_valid = 1'b1; cout_data = res; end
    n = 0;
    while (!m_civ && n < 3000) begin
      tick; n++;
      if (m_cor) seen_ready = 1;
    end
    check_val("in_valid_timeout", n < 3000, 1'b1);
    check_val("core_in_data", m_cid, exp_in);
    check_val("busy_in_send", m_busy, 1'b1);
    for (int unsigned i = 0; i < in_hold; i++) begin
      tick;
      if (m_cor) seen_ready = 1;
      check_val("in_hold_valid", m_civ, 1'b1);
      check_val("in_hold_data", m_cid, exp_in);
    end
    if (early) check_val("early_out_ignored", seen_ready, 1'b0);
    cin_ready = 1'b1;
    tick;
    cin_ready = 1'b0;
    check_val("in_valid_drop", m_civ, 1'b0);
    cout_valid = 1'b1; cout_data = res;
    n = 0;
    while (!m_cor && n < 100) begin tick; n++; end
    check_val("out_ready_timeout", n < 100, 1'b1);
    tick;
    cout_valid = 1'b0;
    check_val("out_ready_drop", m_cor, 1'b0);
    n = 0;
    while (tx_log.size() < 2 && n < 3000) begin tick; n++; end
    check_val("tx_count", tx_log.size(), 2);
    repeat (2) tick;
    if (tx_log.size() >= 2) begin
      check_val("tx_byte0", tx_log[0], t0);
      check_val("tx_byte1", tx_log[1], t1);
    end
    check_val("frame_count", m_fc, exp_fc);
    check_val("busy_idle", m_busy, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] seq;
    int unsigned n;
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    cin_ready = 1'b0; cout_valid = 1'b0; cout_data = '0;
    repeat (3) tick;
    check_outs_zero("reset");

    // Test 1: zero-wait slave, big endian
    load4(32'h12345678);
    ops.delete();
    rst_a = 1'b0;
    check_val("no_cmd_before_edge", m_rd | m_wr, 1'b0);
    tick;
    check_val("first_status_read", {m_rd, m_wr, m_addr}, {1'b1, 1'b0, 5'd8});
    run_frame(32'h12345678, 16'hABCD, 0, 0, 8'hAB, 8'hCD, 16'd1);
    seq = '0;
    if (ops.size() >= 12) for (int i = 0; i < 12; i++) seq = {seq[43:0], ops[i]};
    check_val("op_sequence", seq, 48'h121212121313);

    // Test 2: RRDY withheld for five status reads
    ops.delete();
    rrdy_block = 5;
    load4(32'hC0FFEE01);
    run_frame(32'hC0FFEE01, 16'h5A3C, 0, 0, 8'h5A, 8'h3C, 16'd2);
    n = 0;
    while (n < ops.size() && ops[n] == 4'd1) n++;
    check_val("status_before_rx", n, 6);

    // Test 3: random waitrequest on every access
    wait_mode = 1;
    load4(32'hDEADBEEF);
    run_frame(32'hDEADBEEF, 16'h0102, 0, 0, 8'h01, 8'h02, 16'd3);
    load4(32'h00FF00FF);
    run_frame(32'h00FF00FF, 16'hFF00, 0, 0, 8'hFF, 8'h00, 16'd4);
    load4(32'h80000001);
    run_frame(32'h80000001, 16'h8001, 0, 0, 8'h80, 8'h01, 16'd5);
    wait_mode = 0;

    // Test 4: core_in_ready held off, result offered early
    load4(32'h13579BDF);
    run_frame(32'h13579BDF, 16'h2468, 10, 1, 8'h24, 8'h68, 16'd6);

    // Test 5: reset during a pending read after two RX bytes
    rx_served = 0; hold_en = 1;
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
    n = 0;
    while (!(m_rd && wreq && rx_served >= 2) && n < 500) begin tick; n++; end
    check_val("pending_read", m_rd & wreq, 1'b1);
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;
    check_outs_zero("midreset");
    hold_en = 0; rx_q.delete();
    load4(32'h9ABCDEF0);
    run_frame(32'h9ABCDEF0, 16'h7E81, 0, 0, 8'h7E, 8'h81, 16'd1);

    // Test 6: little-endian instance and frame_count wrap
    rst_a = 1'b1;
    tick;
    sel = 1'b1;
    rx_q.delete();
    load4(32'h12345678);
    tick;
    rst_b = 1'b0;
    run_frame(32'h78563412, 16'hABCD, 0, 0, 8'hCD, 8'hAB, 16'd1);
    force dut_b.frame_cnt_q = 16'hFFFF;
    tick;
    release dut_b.frame_cnt_q;
    tick;
    check_val("fc_preset", m_fc, 16'hFFFF);
    load4(32'h01020304);
    run_frame(32'h04030201, 16'h1234, 0, 0, 8'h34, 8'h12, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
